// File: rtl/data_mem_pipe.sv
// data_mem_pipe -- word-addressed data memory for the 16-bit RISC datapath.
//
// Accepts one load or store per cycle through a req/ready handshake. Load data
// comes back through an RD_LAT-deep read pipeline with an rvalid strobe. After
// every reset a hardware sweep zeroes the whole array before ready rises.
// Addresses at or beyond DEPTH are flagged on err and never alias.
//
// Optional feature macro: DMEM_BYTE_WRITE_EN adds the be port for byte-lane stores.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req        request valid
//   we         1 = store, 0 = load
//   addr       word address (ADDR_W bits, compared in full)
//   wdata      store data
//   be         byte-lane write strobes (DMEM_BYTE_WRITE_EN only)
//   ready      request can be accepted this cycle
//   rvalid     rdata/err valid for one cycle
//   rdata      load result; holds its last value while rvalid = 0
//   err        out-of-range access indicator
//   init_done  clear sweep finished
module data_mem_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] be,
`endif
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              init_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH = 2^ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [AW-1:0]     idx;
  logic              acc_ld;
  logic              acc_st;

  logic              pv [RD_LAT];
  logic              pe [RD_LAT];
  logic [DATA_W-1:0] pd [RD_LAT];
  logic              st_err;

  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign idx      = addr[AW-1:0];
  assign acc_ld   = req & ready & ~we;
  assign acc_st   = req & ready & we;

  // Sweep controller; ready/init_done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      cnt       <= '0;
      ready     <= 1'b0;
      init_done <= 1'b0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == AW'(DEPTH - 1)) begin
        state     <= RUN;
        ready     <= 1'b1;
        init_done <= 1'b1;
      end
    end
  end

  // Storage array: no reset term, the sweep provides the zero fill.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (acc_st && in_range) begin
`ifdef DMEM_BYTE_WRITE_EN
        for (int unsigned i = 0; i < DATA_W / 8; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
`else
        mem[idx] <= wdata;
`endif
      end
    end
  end

  // Read pipeline. Data stages only advance behind a valid entry, so the last
  // stage (driving rdata) holds the previous load result while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        pv[k] <= 1'b0;
        pe[k] <= 1'b0;
        pd[k] <= '0;
      end
      st_err <= 1'b0;
    end else begin
      pv[0] <= acc_ld;
      pe[0] <= acc_ld & ~in_range;
      if (acc_ld) pd[0] <= in_range ? mem[idx] : '0;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        pv[k] <= pv[k-1];
        pe[k] <= pe[k-1];
        if (pv[k-1]) pd[k] <= pd[k-1];
      end
      st_err <= acc_st & ~in_range;
    end
  end

  assign rvalid = pv[RD_LAT-1];
  assign rdata  = pd[RD_LAT-1];
  // Store errors report one cycle after accept, independent of RD_LAT.
  assign err    = pe[RD_LAT-1] | st_err;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Self-checking bench for data_mem_pipe. Three instances with RD_LAT = 1, 2, 3
// share one stimulus stream; a vector table drives RUN-mode traffic and each
// instance's expected outputs are taken from the table row RD_LAT-1 back.
// Hand-written sequences cover reset, sweep length, reset during an in-flight
// load, requests during the sweep, and byte-lane stores when enabled.
module tb_data_mem_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
`ifdef DMEM_BYTE_WRITE_EN
  logic [1:0]  be;
`endif

  logic [3:1]  rdy;
  logic [3:1]  rv;
  logic [3:1]  er;
  logic [3:1]  idn;
  logic [15:0] rd [1:3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(1)) u1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_WRITE_EN
    .be(be),
`endif
    .ready(rdy[1]), .rvalid(rv[1]), .rdata(rd[1]), .err(er[1]), .init_done(idn[1]));

  data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(2)) u2 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_WRITE_EN
    .be(be),
`endif
    .ready(rdy[2]), .rvalid(rv[2]), .rdata(rd[2]), .err(er[2]), .init_done(idn[2]));

  data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(3)) u3 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_WRITE_EN
    .be(be),
`endif
    .ready(rdy[3]), .rvalid(rv[3]), .rdata(rd[3]), .err(er[3]), .init_done(idn[3]));

  typedef struct {
    logic        rq;
    logic        wr;
    logic [15:0] a;
    logic [15:0] wd;
    logic        ev;
    logic [15:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rq, logic wr, logic [15:0] a, logic [15:0] wd,
                              logic ev, logic [15:0] ed, logic ee);
    vec_t v;
    v.rq = rq; v.wr = wr; v.a = a; v.wd = wd; v.ev = ev; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int lat, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (RD_LAT=%0d): got %0h, expected %0h", nm, lat, act, exp);
    end
  endtask

  // Runs the clear sweep with whatever request is on the inputs and checks
  // that every instance raises ready/init_done on exactly the 256th edge.
  task automatic sweep(input string nm);
    int first [1:3];
    for (int l = 1; l <= 3; l++) first[l] = 0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      for (int l = 1; l <= 3; l++)
        if (rdy[l] === 1'b1 && first[l] == 0) first[l] = n;
      if (rdy === 3'b111) break;
    end
    for (int l = 1; l <= 3; l++) begin
      chk({nm, "_ready_edge"}, l, first[l], 256);
      chk({nm, "_init_done"}, l, 32'(idn[l]), 1);
    end
  endtask

  task automatic ld_check(input logic [15:0] a, input logic [15:0] e, input string nm);
    req = 1'b1; we = 1'b0; addr = a;
    tick();
    req = 1'b0;
    for (int l = 1; l <= 3; l++) begin
      if (l > 1) tick();
      chk({nm, "_rvalid"}, l, 32'(rv[l]), 1);
      chk({nm, "_rdata"}, l, 32'(rd[l]), 32'(e));
      chk({nm, "_err"}, l, 32'(er[l]), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
`ifdef DMEM_BYTE_WRITE_EN
    be = 2'b11;
`endif

    // rq wr addr     wdata    ev ed       ee
    tbl.push_back(mk(1, 0, 16'h00FF, 16'h0000, 1, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 16'd16,   16'd10000, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 16'd16,   16'h0000, 1, 16'd10000, 0));
    tbl.push_back(mk(1, 1, 16'd1,    16'h1111, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 16'd2,    16'h2222, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 16'd3,    16'h3333, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 16'd3,    16'h0000, 1, 16'h3333, 0));
    tbl.push_back(mk(1, 0, 16'd1,    16'h0000, 1, 16'h1111, 0));
    tbl.push_back(mk(1, 0, 16'd2,    16'h0000, 1, 16'h2222, 0));
    tbl.push_back(mk(0, 0, 16'd0,    16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 16'd255,  16'hABCD, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 16'd255,  16'h0000, 1, 16'hABCD, 0));
    tbl.push_back(mk(1, 1, 16'd300,  16'hBEEF, 0, 16'h0000, 1));
    tbl.push_back(mk(1, 0, 16'd300,  16'h0000, 1, 16'h0000, 1));
    tbl.push_back(mk(1, 0, 16'd44,   16'h0000, 1, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 16'd256,  16'h1234, 0, 16'h0000, 1));
    tbl.push_back(mk(1, 0, 16'hFFFF, 16'h0000, 1, 16'h0000, 1));
    tbl.push_back(mk(1, 0, 16'd0,    16'h0000, 1, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 16'd0,    16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 16'd0,    16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 16'd0,    16'h0000, 0, 16'h0000, 0));

    // Reset values
    tick(); tick();
    for (int l = 1; l <= 3; l++) begin
      chk("rst_ready", l, 32'(rdy[l]), 0);
      chk("rst_rvalid", l, 32'(rv[l]), 0);
      chk("rst_rdata", l, 32'(rd[l]), 0);
      chk("rst_err", l, 32'(er[l]), 0);
      chk("rst_init_done", l, 32'(idn[l]), 0);
    end
    reset = 1'b0;
    sweep("sweep1");

    // Table-driven RUN traffic
    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].rq; we = tbl[i].wr; addr = tbl[i].a; wdata = tbl[i].wd;
      tick();
      for (int l = 1; l <= 3; l++) begin
        int          j;
        logic        e_rv;
        logic        e_err;
        logic [15:0] e_rd;
        j     = i - (l - 1);
        e_rv  = (j >= 0) ? tbl[j].ev : 1'b0;
        e_rd  = (j >= 0) ? tbl[j].ed : 16'h0000;
        e_err = ((j >= 0) && tbl[j].rq && !tbl[j].wr) ? tbl[j].ee : 1'b0;
        if (tbl[i].rq && tbl[i].wr) e_err = e_err | tbl[i].ee;
        chk($sformatf("vec%0d_rvalid", i), l, 32'(rv[l]), 32'(e_rv));
        chk($sformatf("vec%0d_err", i), l, 32'(er[l]), 32'(e_err));
        if (e_rv) chk($sformatf("vec%0d_rdata", i), l, 32'(rd[l]), 32'(e_rd));
      end
    end
    req = 1'b0;

`ifdef DMEM_BYTE_WRITE_EN
    req = 1'b1; we = 1'b1; addr = 16'd5; wdata = 16'hAABB; be = 2'b11; tick();
    wdata = 16'h1234; be = 2'b01; tick();
    wdata = 16'hFFFF; be = 2'b00; tick();
    req = 1'b0; be = 2'b11;
    ld_check(16'd5, 16'hAA34, "byte_lane");
`endif

    // Reset one cycle after a load accept: the load must never complete
    req = 1'b1; we = 1'b0; addr = 16'd16;
    tick();
    chk("midrst_rv_lat1", 1, 32'(rv[1]), 1);
    chk("midrst_rd_lat1", 1, 32'(rd[1]), 10000);
    req = 1'b0; reset = 1'b1;
    tick();
    for (int l = 1; l <= 3; l++) begin
      chk("midrst_rvalid_a", l, 32'(rv[l]), 0);
      chk("midrst_ready", l, 32'(rdy[l]), 0);
    end
    tick();
    for (int l = 1; l <= 3; l++) begin
      chk("midrst_rvalid_b", l, 32'(rv[l]), 0);
      chk("midrst_init_done", l, 32'(idn[l]), 0);
    end

    // Stores presented during the sweep must be ignored
    reset = 1'b0; req = 1'b1; we = 1'b1; addr = 16'd7; wdata = 16'h5555;
    sweep("sweep2");
    req = 1'b0;
    ld_check(16'd16, 16'h0000, "post_clear16");
    ld_check(16'd7, 16'h0000, "clear_req_ignored");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_pipe.md
# data_mem_pipe

Parametrised, clocked data memory for the 16-bit RISC datapath, sitting between the load/store stage and the word-addressed data store. It accepts one load or store request per cycle through a req/ready handshake and returns load data through a configurable-depth read pipeline with a valid strobe. After every reset it runs a hardware clear sweep that zeroes the whole array before it accepts traffic. It also flags out-of-range addresses instead of aliasing them.

## Interface
Parameters:
- DATA_W, 16, data word width in bits; must be a multiple of 8.
- ADDR_W, 16, address port width in bits; word address.
- DEPTH, 256, number of words; 2 ≤ DEPTH ≤ 2^ADDR_W.
- RD_LAT, 1, load latency in cycles, from the accept edge to rvalid; legal range 1..4.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid.
- we  in  1  1 = store, 0 = load; sampled with req.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  store data.
- be  in  DATA_W/8  byte-lane write strobes; present only with DMEM_BYTE_WRITE_EN.
- ready  out  1  block can accept a request this cycle.
- rvalid  out  1  rdata/err valid for one cycle.
- rdata  out  DATA_W  load result.
- err  out  1  out-of-range access indicator.
- init_done  out  1  clear sweep finished.

## Operation
- State machine has two states, CLEAR and RUN. Reset forces CLEAR and sets the sweep counter to 0.
- CLEAR:
  - Writes 0 to word[cnt] each cycle and increments cnt.
  - When cnt = DEPTH-1 is written, moves to RUN on that edge.
  - ready = 0 throughout. Any req is ignored and not queued.
- RUN:
  - ready = 1 every cycle; no back-pressure.
  - A request is accepted on a rising edge with req & ready.
- Store accept:
  - If addr < DEPTH, word[addr] ← wdata at the accept edge.
  - If addr ≥ DEPTH, the array is unchanged and err pulses high for exactly one cycle, the cycle after the accept edge, with rvalid = 0.
- Load accept:
  - Enters the read pipeline. RD_LAT cycles later, rvalid = 1 for one cycle.
  - rdata = word[addr] as of the accept edge.
  - An out-of-range load returns rdata = 0 with err = 1 alongside rvalid.
- Pipeline ordering:
  - Loads complete strictly in issue order.
  - Back-to-back loads produce back-to-back rvalid pulses.
- Read/write ordering:
  - A load accepted the cycle after a store to the same address returns the new data.
  - A load and a store never coincide, since there is one request per cycle.
- Address comparison uses the full ADDR_W bits. No truncation or aliasing.

## Timing
- Reset values: ready = 0, rvalid = 0, rdata = 0, err = 0, init_done = 0. Read pipeline flushed.
- Clear sweep:
  - The first clearing edge is the first edge with reset low.
  - ready and init_done rise after DEPTH clock edges with reset low, and stay high until the next reset.
- Load latency is exactly RD_LAT cycles. With RD_LAT = 1, a load accepted at edge N gives rvalid high during cycle N+1.
- rdata holds its last value when rvalid = 0. It is not required to be zero.
- Reset mid-operation:
  - In-flight loads are dropped and produce no rvalid.
  - An accepted store completes only if its edge precedes the reset edge.
  - The clear sweep restarts from word 0.
- Throughput is one request per cycle in RUN.

## Configuration
- Macro: DMEM_BYTE_WRITE_EN.
- Defined:
  - The be port exists.
  - A store writes only the byte lanes whose be bit is 1; lane i is bits 8i+7..8i.
  - A store with be = 0 is accepted and writes nothing.
  - An out-of-range store still flags err, regardless of be.
- Undefined:
  - No be port.
  - Every store writes the full word.

## Test plan
- Reset for 2 cycles, then release → ready = 0 for exactly 256 cycles (DEPTH = 256). init_done = 1 on cycle 256. A load of addr 0xFF returns 0.
- In RUN, store addr 16 ← 10000, then load addr 16 on the next cycle → rvalid one cycle after the load accept (RD_LAT = 1), rdata = 16'd10000, err = 0.
- With RD_LAT = 3: store 1→0x1111, 2→0x2222, 3→0x3333, then loads 3, 1, 2 back-to-back → three consecutive rvalid pulses carrying 0x3333, 0x1111, 0x2222, the first 3 cycles after the first load.
- Store addr 300 (0x012C) ← 0xBEEF → err pulse with rvalid = 0. Load addr 300 → rvalid = 1, err = 1, rdata = 0. Load addr 44 (300 mod 256) → rdata = 0, confirming no aliasing.
- Issue a load with RD_LAT = 2, then assert reset one cycle later → no rvalid. The clear sweep restarts, and a previously stored addr 16 reads 0 after init_done.
- With DMEM_BYTE_WRITE_EN: store addr 5 ← 0xAABB with be = 2'b11, then store 0x1234 with be = 2'b01, then load addr 5 → rdata = 0xAA34.
